// File: rtl/line_memory_responder.sv
// Memory-side responder: services one cache-line fill or writeback at a time from a line-wide array.
// Latency: READ_LATENCY cycles from accept to o_memory_response, WRITE_LATENCY cycles to o_wr_ack.
// Backpressure: o_req_ready drops on accept and returns in the response/ack cycle; no request queue.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   i_req_valid/o_req_ready  request handshake; i_req_write selects writeback (1) or fill (0)
//   i_req_addr          line address, offset bits and bits above the index are ignored
//   i_req_line          writeback data; o_memory_line fill data (held until the next fill)
//   o_memory_response   one-cycle fill-complete pulse; o_wr_ack one-cycle writeback-complete pulse
//   o_busy              request in flight (inverse of o_req_ready)
module line_memory_responder #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int OFFSET_BITS     = 6,
  parameter int MEM_INDEX_BITS  = 10,
  parameter int READ_LATENCY    = 8,
  parameter int WRITE_LATENCY   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic                         i_req_write,
  input  logic [ADDRESS_WIDTH-1:0]     i_req_addr,
  input  logic [8*LINE_SIZE_BYTES-1:0] i_req_line,
  output logic [8*LINE_SIZE_BYTES-1:0] o_memory_line,
  output logic                         o_memory_response,
  output logic                         o_wr_ack,
  output logic                         o_busy
);

  localparam int LINE_SIZE_BITS = 8 * LINE_SIZE_BYTES;
  localparam int DEPTH          = 2 ** MEM_INDEX_BITS;
  localparam int MAX_LAT        = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  // Counter only ever holds LATENCY-1 down to 0.
  localparam int CNT_W          = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [MEM_INDEX_BITS-1:0] idx_q, idx_d;
  logic [LINE_SIZE_BITS-1:0] wline_q, wline_d;
  logic [LINE_SIZE_BITS-1:0] rline_q, rline_d;
  logic                      rsp_q, rsp_d;
  logic                      ack_q, ack_d;
  logic                      mem_we;

  // Backing store; deliberately not reset so contents survive a reset.
  logic [LINE_SIZE_BITS-1:0] mem [DEPTH];

  // Offset bits and bits above the index are intentionally dropped (addresses alias).
  logic unused_addr;
  assign unused_addr = ^i_req_addr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wline_d = wline_q;
    rline_d = rline_q;
    rsp_d   = 1'b0;
    ack_d   = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          idx_d = i_req_addr[OFFSET_BITS +: MEM_INDEX_BITS];
          if (i_req_write) begin
            wline_d = i_req_line;
            cnt_d   = WR_INIT;
            state_d = WR_WAIT;
          end else begin
            cnt_d   = RD_INIT;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rline_d = mem[idx_q];
          rsp_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Commit happens only here, so a reset during the wait leaves storage untouched.
          mem_we  = 1'b1;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wline_q <= '0;
      rline_q <= '0;
      rsp_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      rsp_q   <= rsp_d;
      ack_q   <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[idx_q] <= wline_q;
    end
  end

  assign o_req_ready       = (state_q == IDLE);
  assign o_busy            = (state_q != IDLE);
  assign o_memory_line     = rline_q;
  assign o_memory_response = rsp_q;
  assign o_wr_ack          = ack_q;

endmodule

// File: tb/tb_line_memory_responder.sv
module tb_line_memory_responder;

  localparam logic [511:0] L_A5   = {16{32'hA5A5_0001}};
  localparam logic [511:0] L_DEAD = {16{32'hDEAD_BEEF}};
  localparam logic [511:0] L_12   = {16{32'h1234_5678}};

  logic clk = 1'b0;
  logic rst;

  // Instance A: default latencies. Instance B: latency 1 for both.
  logic         a_valid, a_rdy, a_write, a_rsp, a_ack, a_busy;
  logic [31:0]  a_addr;
  logic [511:0] a_wline, a_line;
  logic         b_valid, b_rdy, b_write, b_rsp, b_ack, b_busy;
  logic [31:0]  b_addr;
  logic [511:0] b_wline, b_line;

  line_memory_responder u_dut_a (
    .clk(clk), .rst(rst),
    .i_req_valid(a_valid), .o_req_ready(a_rdy), .i_req_write(a_write),
    .i_req_addr(a_addr), .i_req_line(a_wline), .o_memory_line(a_line),
    .o_memory_response(a_rsp), .o_wr_ack(a_ack), .o_busy(a_busy)
  );

  line_memory_responder #(.READ_LATENCY(1), .WRITE_LATENCY(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .i_req_valid(b_valid), .o_req_ready(b_rdy), .i_req_write(b_write),
    .i_req_addr(b_addr), .i_req_line(b_wline), .o_memory_line(b_line),
    .o_memory_response(b_rsp), .o_wr_ack(b_ack), .o_busy(b_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           wr;
    bit           chk_data;
    logic [511:0] line;
    int           done;
    int           lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   low_run[2];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every pulse must match the oldest expectation of its instance.
  task automatic mon(input int inst, input logic rsp, input logic ack, input logic rdy,
                     input logic busy, input logic [511:0] line);
    exp_t  e;
    int    sz;
    string p;
    p = (inst != 0) ? "b_" : "a_";
    chk({p, "busy_vs_ready"}, busy, !rdy);
    if (!rdy) low_run[inst]++;
    if (rsp || ack) begin
      chk({p, "pulse_overlap"}, rsp & ack, 0);
      sz = (inst != 0) ? qb.size() : qa.size();
      chk({p, "pulse_expected"}, sz != 0, 1);
      if (sz != 0) begin
        if (inst != 0) e = qb.pop_front();
        else           e = qa.pop_front();
        chk({p, "pulse_kind_is_ack"}, ack, e.wr);
        chk({p, "pulse_cycle"}, cyc, e.done);
        chk({p, "ready_low_cycles"}, low_run[inst], e.lat);
        chk({p, "ready_in_pulse"}, rdy, 1);
        if (!e.wr && e.chk_data) chk({p, "fill_data"}, line, e.line);
      end
    end
    if (rdy) low_run[inst] = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, a_rsp, a_ack, a_rdy, a_busy, a_line);
      mon(1, b_rsp, b_ack, b_rdy, b_busy, b_line);
    end
  end

  task automatic drive(input int inst, input logic v, input logic w,
                       input logic [31:0] addr, input logic [511:0] line);
    if (inst != 0) begin
      b_valid = v; b_write = w; b_addr = addr; b_wline = line;
    end else begin
      a_valid = v; a_write = w; a_addr = addr; a_wline = line;
    end
  endtask

  // Called at a falling edge; holds valid until accepted, returns at the falling edge after accept.
  task automatic send(input int inst, input logic wr, input logic [31:0] addr,
                      input logic [511:0] line, input bit expect_rsp, input bit chk_data,
                      input logic [511:0] exp_line, output int acc);
    int   n;
    exp_t e;
    drive(inst, 1'b1, wr, addr, line);
    n = 0;
    while (!((inst != 0) ? b_rdy : a_rdy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait_bound", n < 200, 1);
    acc = cyc + 1;
    @(negedge clk);
    drive(inst, 1'b0, 1'b0, 32'h0, 512'h0);
    chk("busy_after_accept", (inst != 0) ? b_busy : a_busy, 1);
    if (expect_rsp) begin
      e.wr       = wr;
      e.chk_data = chk_data;
      e.line     = exp_line;
      e.lat      = (inst != 0) ? 1 : (wr ? 4 : 8);
      e.done     = acc + e.lat;
      if (inst != 0) qb.push_back(e);
      else           qa.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_bound", n < 200, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc1, acc2, acc3, acc_x;
    rst = 1'b1;
    low_run[0] = 0;
    low_run[1] = 0;
    drive(0, 1'b0, 1'b0, 32'h0, 512'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 512'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values
    chk("rst_a_ready", a_rdy, 1);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_rsp", a_rsp, 0);
    chk("rst_a_ack", a_ack, 0);
    chk("rst_a_line", a_line, 0);
    chk("rst_b_ready", b_rdy, 1);
    chk("rst_b_line", b_line, 0);

    // Write then read of the same line at a different offset
    send(0, 1'b1, 32'h0000_1040, L_A5, 1, 0, 512'h0, acc_x);
    drain();
    send(0, 1'b0, 32'h0000_1058, 512'h0, 1, 1, L_A5, acc1);

    // Back-to-back: next read held valid through the response cycle
    send(0, 1'b0, 32'h0000_2000, 512'h0, 1, 0, 512'h0, acc2);
    chk("b2b_accept_edge", acc2, acc1 + 8 + 1);

    // One-cycle valid pulse while busy must be ignored
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0000_3000, 512'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 512'h0);
    chk("busy_during_pulse", a_rdy, 0);
    // Held valid is accepted only once ready returns
    send(0, 1'b0, 32'h0000_3000, 512'h0, 1, 0, 512'h0, acc3);
    chk("held_accept_edge", acc3, acc2 + 8 + 1);
    drain();
    repeat (12) @(negedge clk);

    // Reset two cycles into a write: no ack, storage unchanged
    send(0, 1'b1, 32'h0000_1040, L_DEAD, 0, 0, 512'h0, acc_x);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", a_rdy, 1);
    chk("midrst_busy", a_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_no_ack_line", a_line, 0);
    send(0, 1'b0, 32'h0000_1040, 512'h0, 1, 1, L_A5, acc_x);
    drain();

    // Latency 1 and index aliasing on instance B
    send(1, 1'b1, 32'h0001_0040, L_12, 1, 0, 512'h0, acc_x);
    drain();
    send(1, 1'b0, 32'h0000_0040, 512'h0, 1, 1, L_12, acc_x);
    drain();

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_memory_responder.md
Name: line_memory_responder

Overview:
- Memory-side responder for the 4-way set-associative cache controller's miss/evict interface; the target end of that interface.
- Services one outstanding cache-line request at a time: line fill (read) or dirty-line writeback (write).
- Fixed, parameterised latency per request type, backed by an internal line-wide storage array.
- Used as the main-memory model in cache testbenches and as the synthesisable backing store in small configurations.

Parameters:
- ADDRESS_WIDTH, 32, request address width.
- LINE_SIZE_BYTES, 64, cache line size; LINE_SIZE_BITS = 8*LINE_SIZE_BYTES.
- OFFSET_BITS, 6, byte-offset bits ignored in line addressing; must equal log2(LINE_SIZE_BYTES).
- MEM_INDEX_BITS, 10, storage depth = 2**MEM_INDEX_BITS lines.
- READ_LATENCY, 8, cycles from read accept to o_memory_response; legal range is >=1.
- WRITE_LATENCY, 4, cycles from write accept to o_wr_ack; legal range is >=1.

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- i_req_valid, in, 1, request present.
- o_req_ready, out, 1, responder idle; can accept a request.
- i_req_write, in, 1, 1 = writeback, 0 = line fill.
- i_req_addr, in, ADDRESS_WIDTH, line address; offset bits ignored.
- i_req_line, in, LINE_SIZE_BITS, writeback data.
- o_memory_line, out, LINE_SIZE_BITS, fill data.
- o_memory_response, out, 1, one-cycle fill-complete pulse.
- o_wr_ack, out, 1, one-cycle writeback-complete pulse.
- o_busy, out, 1, request in flight; equals !o_req_ready.

Behaviour:
- Reset (rst is asynchronous, active-high; clock is clk):
  - state = IDLE; o_req_ready = 1.
  - o_memory_response, o_wr_ack, o_busy = 0; o_memory_line = 0.
  - Latency counter = 0. Storage contents are not cleared.
- Accept: at a rising edge where i_req_valid && o_req_ready.
  - Latch write flag, index and line data.
  - Index = i_req_addr[OFFSET_BITS +: MEM_INDEX_BITS]. Bits above the index are ignored, so addresses alias modulo the depth.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
  - IDLE: on accept, go to RD_WAIT or WR_WAIT; counter = LATENCY-1.
  - RD_WAIT / WR_WAIT: while counter != 0, decrement the counter. At the edge where counter == 0, go to IDLE and complete the request.
- Read completion: at the completing edge, o_memory_line <= mem[index] and o_memory_response <= 1 for exactly one cycle.
  - o_memory_line then holds its value until the next read completion.
- Write completion: at the completing edge, mem[index] <= latched line and o_wr_ack <= 1 for exactly one cycle.
  - Storage is updated only at completion, never at accept.
- Timing: accept at edge k puts the response/ack high in the cycle after edge k+LATENCY.
  - o_req_ready is low from edge k to edge k+LATENCY.
  - o_req_ready is high again in the same cycle as the response pulse.
- Back-to-back: a request presented in the response cycle is accepted at the next edge, with no bubble.
- Ordering:
  - Requests complete strictly in order; there is no queue.
  - A read issued after a write ack to the same index returns the written data.
- Valid/ready rules:
  - i_req_valid while o_req_ready = 0 is ignored and not stored.
  - The initiator must hold valid, write, addr and line stable until accepted.
  - Latched values are unaffected by input changes after accept.
- Reset mid-operation: the in-flight request is dropped.
  - No response or ack is produced.
  - A pending write is not committed; storage keeps its old value.
- Pulses never overlap: o_memory_response and o_wr_ack are never high together, and each is 0 in every non-completion cycle.

Test Plan:
1. Reset values: assert rst, then release -> o_req_ready = 1; o_busy, o_memory_response, o_wr_ack = 0; o_memory_line = 0.
2. Write then read, default latencies:
   - Write addr 0x0000_1040, line = {16{32'hA5A5_0001}} -> o_wr_ack exactly 4 cycles after accept; o_req_ready low for 4 cycles.
   - Then read addr 0x0000_1058 (same line, different offset) -> o_memory_response 8 cycles after accept; o_memory_line = {16{32'hA5A5_0001}}.
3. Back-to-back: hold i_req_valid through the response cycle with read addr 0x0000_2000 -> accepted at the edge following the response; second response arrives exactly 8 cycles later; no cycle gap.
4. Busy rejection:
   - Pulse a read of 0x0000_3000 for one cycle mid-RD_WAIT -> ignored; no extra response.
   - Hold it valid -> accepted only once o_req_ready = 1.
5. Reset mid-write: write {16{32'hDEAD_BEEF}} to 0x0000_1040, assert rst 2 cycles after accept -> no o_wr_ack. A following read of 0x0000_1040 returns {16{32'hA5A5_0001}}.
6. Aliasing and latency 1:
   - READ_LATENCY = WRITE_LATENCY = 1; write 0x0001_0040 with {16{32'h1234_5678}} -> ack in the next cycle.
   - Read 0x0000_0040 (same index 1) -> response in the next cycle with {16{32'h1234_5678}}.
